// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sends a sync pattern then a latched payload MSB-first,
// one bit per clock, followed by a forced-low gap before accepting the next frame.
module seq_frame_tx #(
  parameter int               DATA_W  = 8,
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b11011,
  parameter int               GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              out,
  output logic              out_valid,
  output logic              done
);

  localparam int MAX_PD  = (PAT_W > DATA_W) ? PAT_W : DATA_W;
  localparam int MAX_ALL = (MAX_PD > GAP_CYC) ? MAX_PD : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] PAT_LAST = CNT_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DAT_PEN  = CNT_W'((DATA_W > 1) ? DATA_W - 2 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              bit_p0, bit_d;
  logic              vld_p0, vld_d;
  logic              done_p0, done_d;
  logic              rdy_p0, rdy_d;

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    dat_d   = dat_q;
    bit_d   = 1'b0;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    rdy_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SYNC;
          cnt_d   = '0;
          pat_d   = PATTERN << 1;
          dat_d   = data_in;
          bit_d   = PATTERN[PAT_W-1];
          vld_d   = 1'b1;
        end else begin
          rdy_d   = 1'b1;
        end
      end

      SYNC: begin
        vld_d = 1'b1;
        if (cnt_q == PAT_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = dat_q[DATA_W-1];
          dat_d   = dat_q << 1;
          done_d  = (DATA_W == 1);
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          bit_d   = pat_q[PAT_W-1];
          pat_d   = pat_q << 1;
        end
      end

      DATA: begin
        if (cnt_q == DAT_LAST) begin
          cnt_d = '0;
          if (GAP_CYC > 0) begin
            state_d = GAP;
          end else begin
            state_d = IDLE;
            rdy_d   = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          bit_d  = dat_q[DATA_W-1];
          dat_d  = dat_q << 1;
          vld_d  = 1'b1;
          done_d = (cnt_q == DAT_PEN);
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          rdy_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        rdy_d   = 1'b1;
      end
    endcase
  end

  // Stage p0: state, shifters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      dat_q   <= '0;
      bit_p0  <= 1'b0;
      vld_p0  <= 1'b0;
      done_p0 <= 1'b0;
      rdy_p0  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      dat_q   <= dat_d;
      bit_p0  <= bit_d;
      vld_p0  <= vld_d;
      done_p0 <= done_d;
      rdy_p0  <= rdy_d;
    end
  end

  assign out       = bit_p0;
  assign out_valid = vld_p0;
  assign done      = done_p0;
  assign ready     = rdy_p0;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: reset, single frame, back-to-back, busy ignore,
// mid-frame reset and a loopback into an 11011 overlapping Mealy detector model.
module tb_seq_frame_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic       ready;
  logic       out;
  logic       out_valid;
  logic       done;

  int checks;
  int errors;

  seq_frame_tx #(
    .DATA_W (8),
    .PAT_W  (5),
    .PATTERN(5'b11011),
    .GAP_CYC(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .ready    (ready),
    .out      (out),
    .out_valid(out_valid),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    data_in = 8'h00;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({ready, out, out_valid, done} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got rdy/out/vld/done=%b want 1000", i,
                 {ready, out, out_valid, done});
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({ready, out, out_valid, done} !== 4'b1000) begin
        errors++;
        $display("FAIL idle cyc %0d: got rdy/out/vld/done=%b want 1000", i,
                 {ready, out, out_valid, done});
      end
    end
  endtask

  task automatic test_single();
    logic [12:0] frame;
    frame = 13'b11011_10100101;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready_pre: got %b want 1", ready);
    end
    start = 1'b1;
    data_in = 8'hA5;
    tick();
    start = 1'b0;
    data_in = 8'h00;
    for (int i = 0; i < 13; i++) begin
      checks++;
      if ({out, out_valid, done, ready} !== {frame[12-i], 1'b1, (i == 12), 1'b0}) begin
        errors++;
        $display("FAIL single_bit %0d: got out/vld/done/rdy=%b want %b", i + 1,
                 {out, out_valid, done, ready}, {frame[12-i], 1'b1, (i == 12), 1'b0});
      end
      tick();
    end
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({out, out_valid, done, ready} !== 4'b0000) begin
        errors++;
        $display("FAIL single_gap %0d: got out/vld/done/rdy=%b want 0000", g,
                 {out, out_valid, done, ready});
      end
      tick();
    end
    checks++;
    if ({ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL single_idle_return: got rdy/vld=%b want 10", {ready, out_valid});
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] f1;
    logic [12:0] f2;
    int          quiet;
    f1 = 13'b11011_00111100;
    f2 = 13'b11011_11000011;
    start = 1'b1;
    data_in = 8'h3C;
    tick();
    data_in = 8'hC3;
    for (int i = 0; i < 13; i++) begin
      checks++;
      if ({out, out_valid, done} !== {f1[12-i], 1'b1, (i == 12)}) begin
        errors++;
        $display("FAIL b2b_f1_bit %0d: got out/vld/done=%b want %b", i + 1,
                 {out, out_valid, done}, {f1[12-i], 1'b1, (i == 12)});
      end
      tick();
    end
    quiet = 0;
    while (!out_valid && quiet < 10) begin
      checks++;
      if (out !== 1'b0) begin
        errors++;
        $display("FAIL b2b_quiet_out %0d: got %b want 0", quiet, out);
      end
      quiet++;
      tick();
    end
    start = 1'b0;
    checks++;
    if (quiet !== 3) begin
      errors++;
      $display("FAIL b2b_quiet_len: got %0d want 3", quiet);
    end
    for (int i = 0; i < 13; i++) begin
      checks++;
      if ({out, out_valid, done} !== {f2[12-i], 1'b1, (i == 12)}) begin
        errors++;
        $display("FAIL b2b_f2_bit %0d: got out/vld/done=%b want %b", i + 1,
                 {out, out_valid, done}, {f2[12-i], 1'b1, (i == 12)});
      end
      tick();
    end
    tick();
    tick();
    checks++;
    if ({ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_idle_return: got rdy/vld=%b want 10", {ready, out_valid});
    end
  endtask

  task automatic test_busy_ignore();
    logic [12:0] frame;
    int          extra;
    frame = 13'b11011_00000000;
    start = 1'b1;
    data_in = 8'h00;
    tick();
    start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == 1) begin
        start = 1'b1;
        data_in = 8'hFF;
      end else begin
        start = 1'b0;
      end
      checks++;
      if ({out, out_valid, done, ready} !== {frame[12-i], 1'b1, (i == 12), 1'b0}) begin
        errors++;
        $display("FAIL busy_bit %0d: got out/vld/done/rdy=%b want %b", i + 1,
                 {out, out_valid, done, ready}, {frame[12-i], 1'b1, (i == 12), 1'b0});
      end
      tick();
    end
    start = 1'b0;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({out_valid, ready} !== 2'b00) begin
        errors++;
        $display("FAIL busy_gap %0d: got vld/rdy=%b want 00", g, {out_valid, ready});
      end
      tick();
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b0 || ready !== 1'b1) extra++;
      tick();
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_no_extra_frame: got %0d busy cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] frame;
    frame = 13'b11011_01011010;
    start = 1'b1;
    data_in = 8'hFF;
    tick();
    start = 1'b0;
    repeat (7) tick();
    checks++;
    if ({out, out_valid} !== 2'b11) begin
      errors++;
      $display("FAIL rmid_pre: got out/vld=%b want 11", {out, out_valid});
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({out, out_valid, done, ready} !== 4'b0001) begin
      errors++;
      $display("FAIL rmid_async: got out/vld/done/rdy=%b want 0001",
               {out, out_valid, done, ready});
    end
    tick();
    checks++;
    if ({out, out_valid, done, ready} !== 4'b0001) begin
      errors++;
      $display("FAIL rmid_held: got out/vld/done/rdy=%b want 0001",
               {out, out_valid, done, ready});
    end
    rst = 1'b1;
    start = 1'b1;
    data_in = 8'h5A;
    tick();
    start = 1'b0;
    data_in = 8'h00;
    for (int i = 0; i < 13; i++) begin
      checks++;
      if ({out, out_valid, done} !== {frame[12-i], 1'b1, (i == 12)}) begin
        errors++;
        $display("FAIL rmid_frame_bit %0d: got out/vld/done=%b want %b", i + 1,
                 {out, out_valid, done}, {frame[12-i], 1'b1, (i == 12)});
      end
      tick();
    end
    tick();
    tick();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_idle_return: got rdy=%b want 1", ready);
    end
  endtask

  task automatic test_loopback();
    logic [4:0]  hist;
    logic [13:0] hit_mask;
    int          hits;
    int          stray;
    hist = 5'b00000;
    hit_mask = '0;
    hits = 0;
    stray = 0;
    start = 1'b1;
    data_in = 8'hDB;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 22; j++) begin
      hist = {hist[3:0], out};
      if (hist == 5'b11011) begin
        hits++;
        if (j <= 13) hit_mask[j] = 1'b1;
        else stray++;
      end
      tick();
    end
    checks++;
    if (hits !== 3) begin
      errors++;
      $display("FAIL loop_hits: got %0d want 3", hits);
    end
    checks++;
    if (hit_mask !== 14'b10_0100_0010_0000) begin
      errors++;
      $display("FAIL loop_positions: got %b want 10010000100000", hit_mask);
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL loop_stray: got %0d want 0", stray);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
